dm_ext: RTL

//  Parametrised data memory for the MEM stage. Successor to the fixed 4096-word,

---
 rtl/dm_ext_pkg.sv | 15 +
 rtl/dm_ext_lane.sv | 54 +++++
 rtl/dm_ext.sv | 89 ++++++++
 3 files changed

// File: rtl/dm_ext_pkg.sv
// Shared definitions for the MEM-stage data memory.
// Covers access size codes and the clear engine state encoding.
package dm_ext_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   typedef enum logic {
      DM_CLEAR = 1'b0,
      DM_IDLE  = 1'b1
   } dm_state_t;

endpackage

// File: rtl/dm_ext_lane.sv
// Byte-lane steering for the data memory.
// Computes store byte enables and the merged word, plus sign/zero-extended load data.
module dm_lane
   import dm_ext_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] wdat,
   input  logic [31:0] old_word,
   output logic [3:0]  be,
   output logic [31:0] merged,
   output logic [31:0] ld_data
);

   logic [31:0] wrep;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Store data is replicated across lanes so the byte enables alone pick the target bytes
   always_comb begin
      be   = 4'b0000;
      wrep = wdat;
      case (size)
         SIZE_B: begin
            be   = 4'b0001 << lane;
            wrep = {4{wdat[7:0]}};
         end
         SIZE_H: begin
            be   = 4'b0011 << lane;
            wrep = {2{wdat[15:0]}};
         end
         SIZE_W: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         merged[8*b +: 8] = be[b] ? wrep[8*b +: 8] : old_word[8*b +: 8];
      end
   end

   always_comb begin
      byte_v  = old_word[{lane, 3'b000} +: 8];
      half_v  = old_word[{lane[1], 4'b0000} +: 16];
      ld_data = 32'd0;
      case (size)
         SIZE_B:  ld_data = sext ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
         SIZE_H:  ld_data = sext ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
         SIZE_W:  ld_data = old_word;
         default: ld_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/dm_ext.sv
// Parametrised MEM-stage data memory with sub-word access, fault flags and a
// sequential clear engine that stalls the pipeline after reset.
module dm_ext
   import dm_ext_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter bit          TRACE      = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wpc,
   input  logic [31:0] addr,
   input  logic [31:0] wdat,
   input  logic        we,
   input  logic        re,
   input  logic [1:0]  size,
   input  logic        sext,
   output logic [31:0] rdat,
   output logic        busy,
   output logic        fault_align,
   output logic        fault_range
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [31:0]           mem [DEPTH];
   dm_state_t             state;
   logic [DEPTH_LOG2-1:0] cidx;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           off;
   logic [31:0]           old_word;
   logic [31:0]           merged;
   logic [31:0]           ld_data;
   logic [3:0]            be;
   logic [1:0]            lane;
   logic                  access;
   logic                  in_range;
   logic                  bad_align;
   logic                  commit;

   assign off      = addr - BASE_ADDR;
   assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
   assign idx      = off[DEPTH_LOG2+1:2];
   assign lane     = addr[1:0];
   assign access   = we | re;

   assign bad_align   = ((size == SIZE_H) && lane[0]) ||
                        ((size == SIZE_W) && (lane != 2'b00)) ||
                        (size == SIZE_X);
   assign fault_align = access & bad_align;
   assign fault_range = access & ~in_range;

   assign busy     = (state == DM_CLEAR);
   assign old_word = mem[idx];
   assign rdat     = (busy || fault_align || fault_range) ? 32'd0 : ld_data;
   assign commit   = we & ~busy & ~fault_align & ~fault_range & (be != 4'b0000);

   dm_lane u_lane (
      .lane     (lane),
      .size     (size),
      .sext     (sext),
      .wdat     (wdat),
      .old_word (old_word),
      .be       (be),
      .merged   (merged),
      .ld_data  (ld_data)
   );

   // Clearing one word per cycle replaces a full-array reset; stores are locked out until done
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= DM_CLEAR;
         cidx  <= '0;
      end else if (state == DM_CLEAR) begin
         mem[cidx] <= 32'd0;
         cidx      <= cidx + DEPTH_LOG2'(1);
         if (cidx == DEPTH_LOG2'(DEPTH - 1)) begin
            state <= DM_IDLE;
         end
      end else if (commit) begin
         mem[idx] <= merged;
         if (TRACE) begin
            $display("%d@%h: *%h <= %h", $time, wpc, {addr[31:2], 2'b00}, merged);
         end
      end
   end

endmodule
